// File: rtl/phy_pkg.sv
// ----------------------------------------------------------------------------
// phy_pkg
// Shared 802.11 PHY definitions used by the transmit and receive paths:
//   - receive deframer state encoding
//   - default framing parameters (N_DBPS, preamble length, tail length)
//   - bit offsets of the 24-bit SIGNAL field. The field is held as a shift
//     word, so the first received bit sits at bit 23.
//   - scrambler polynomial x^7 + x^4 + 1 (taps shared with the TX scrambler)
//   - even-parity helper for the SIGNAL field
// ----------------------------------------------------------------------------
package phy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HUNT    = 3'd1,
        ST_SIGNAL  = 3'd2,
        ST_SERVICE = 3'd3,
        ST_PSDU    = 3'd4,
        ST_TAIL    = 3'd5,
        ST_PAD     = 3'd6
    } rx_state_t;

    localparam int N_DBPS_DEF        = 24;
    localparam int PREAMBLE_BITS_DEF = 96;
    localparam int TAIL_BITS_DEF     = 6;

    localparam int SIGNAL_BITS  = 24;
    localparam int SERVICE_BITS = 16;
    // Leading SERVICE bits are all zero before scrambling, so they carry the seed
    localparam int SEED_BITS    = 7;

    // SIGNAL field layout inside the shift word (first received bit = 23)
    localparam int SIG_RATE_MSB = 23;
    localparam int SIG_RATE_LSB = 20;
    localparam int SIG_RSVD     = 19;
    localparam int SIG_LEN_MSB  = 18;
    localparam int SIG_LEN_LSB  = 7;
    localparam int SIG_PARITY   = 6;
    localparam int SIG_TAIL_MSB = 5;
    localparam int SIG_TAIL_LSB = 0;
    localparam int SIG_PAR_SPAN = SIG_RATE_MSB - SIG_PARITY + 1;

    // Scrambler polynomial x^7 + x^4 + 1
    localparam int SCR_WIDTH  = 7;
    localparam int SCR_TAP_HI = 7;
    localparam int SCR_TAP_LO = 4;

    // True when the covered bits (data plus parity bit) have even parity
    function automatic logic even_parity_ok(input logic [SIG_PAR_SPAN-1:0] bits_i);
        return ((^bits_i) == 1'b0);
    endfunction

endpackage

// File: rtl/descrambler.sv
// ----------------------------------------------------------------------------
// descrambler
// 7-bit additive descrambler for x^7 + x^4 + 1.
// The register holds the last seven sequence bits, with bit 0 the most recent.
// Each new sequence bit is x[n-7] ^ x[n-4].
//   Clock   in  : rising-edge clock
//   Reset   in  : asynchronous active-low reset
//   Load    in  : shift Seed_in straight into the register (seed recovery)
//   Seed_in in  : received bit used during seed recovery
//   Advance in  : shift the generated sequence bit into the register
//   Seq_bit out : current sequence bit to XOR with the received bit
// ----------------------------------------------------------------------------
module descrambler
    import phy_pkg::*;
(
    input  logic Clock,
    input  logic Reset,
    input  logic Load,
    input  logic Seed_in,
    input  logic Advance,
    output logic Seq_bit
);

    logic [SCR_WIDTH-1:0] lfsr_r;

    // Sequence bit is combinational so it can be applied to the bit being consumed
    assign Seq_bit = lfsr_r[SCR_TAP_HI-1] ^ lfsr_r[SCR_TAP_LO-1];

    // LFSR state: serial seed load takes priority over free-running advance
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            lfsr_r <= 7'd0;
        end else if (Load) begin
            lfsr_r <= {lfsr_r[SCR_WIDTH-2:0], Seed_in};
        end else if (Advance) begin
            lfsr_r <= {lfsr_r[SCR_WIDTH-2:0], Seq_bit};
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

endmodule

// File: rtl/rx_deframer.sv
// ----------------------------------------------------------------------------
// rx_deframer
// Receive deframer for the 802.11 bit stream. The block:
//   - locks on the alternating preamble
//   - parses and checks the SIGNAL field
//   - recovers the scrambler seed from SERVICE
//   - descrambles the PSDU and assembles bytes
//   - discards the tail and pad bits, then reports the end of the frame
// Ports:
//   Clock, Reset (async active-low), Start (arm/abort)
//   In_valid/In_bit                       : serial input, gaps allowed
//   Rate[3:0], Length[11:0]               : last accepted SIGNAL contents
//   Signal_ok, Signal_err                 : SIGNAL verdict pulses
//   Data_valid/Data_bit                   : descrambled PSDU bit stream
//   Byte_valid/Data_byte                  : assembled byte, first bit in bit 0
//   Frame_done                            : pulse after the final DATA bit
//   Busy                                  : high in every state except IDLE
// ----------------------------------------------------------------------------
module rx_deframer
    import phy_pkg::*;
#(
    parameter int N_DBPS        = N_DBPS_DEF,
    parameter int PREAMBLE_BITS = PREAMBLE_BITS_DEF,
    parameter int TAIL_BITS     = TAIL_BITS_DEF
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        In_valid,
    input  logic        In_bit,
    output logic [3:0]  Rate,
    output logic [11:0] Length,
    output logic        Signal_ok,
    output logic        Signal_err,
    output logic        Data_valid,
    output logic        Data_bit,
    output logic        Byte_valid,
    output logic [7:0]  Data_byte,
    output logic        Frame_done,
    output logic        Busy
);

    rx_state_t   state_r;
    rx_state_t   state_nxt_s;

    logic [6:0]  run_cnt_r;
    logic [6:0]  run_cnt_nxt_s;
    logic        run_match_s;
    logic        run_hit_s;

    logic [14:0] bit_cnt_r;
    logic [14:0] bit_cnt_inc_s;
    logic [14:0] psdu_last_s;
    logic        sig_last_s;
    logic        svc_last_s;
    logic        psdu_end_s;
    logic        tail_last_s;

    logic [7:0]  sym_cnt_r;
    logic [7:0]  sym_cnt_nxt_s;
    logic        sym_wrap_s;

    logic [22:0] sig_sr_r;
    logic [23:0] sig_word_s;
    logic        sig_good_s;

    logic [6:0]  byte_sr_r;
    logic        consume_s;
    logic        scr_load_s;
    logic        scr_adv_s;
    logic        seq_bit_s;
    logic        plain_bit_s;

    logic [3:0]  rate_r;
    logic [11:0] length_r;
    logic        signal_ok_r;
    logic        signal_err_r;
    logic        data_valid_r;
    logic        data_bit_r;
    logic        byte_valid_r;
    logic [7:0]  data_byte_r;
    logic        frame_done_r;
    logic        busy_r;

    descrambler u_descrambler (
        .Clock   (Clock),
        .Reset   (Reset),
        .Load    (scr_load_s),
        .Seed_in (In_bit),
        .Advance (scr_adv_s),
        .Seq_bit (seq_bit_s)
    );

    // Per-bit decode: consume qualifier, counter end points, SIGNAL check, descrambler controls
    always_comb begin
        // Start wins over a same-cycle input bit, which is then dropped
        consume_s     = In_valid & ~Start;

        // Expected preamble bit is 1 for an even run length (run starts with 1)
        run_match_s   = (In_bit != run_cnt_r[0]);
        if (run_match_s) begin
            run_cnt_nxt_s = run_cnt_r + 7'd1;
        end else begin
            run_cnt_nxt_s = {6'd0, In_bit};
        end
        run_hit_s     = run_match_s && (run_cnt_r == 7'(PREAMBLE_BITS - 1));

        bit_cnt_inc_s = bit_cnt_r + 15'd1;
        psdu_last_s   = {length_r, 3'b000} - 15'd1;
        sig_last_s    = (bit_cnt_r == 15'(SIGNAL_BITS - 1));
        svc_last_s    = (bit_cnt_r == 15'(SERVICE_BITS - 1));
        psdu_end_s    = (bit_cnt_r == psdu_last_s);
        tail_last_s   = (bit_cnt_r == 15'(TAIL_BITS - 1));

        // Symbol counter holds DATA bits consumed so far, mod N_DBPS
        sym_wrap_s    = (sym_cnt_r == 8'(N_DBPS - 1));
        if (sym_wrap_s) begin
            sym_cnt_nxt_s = 8'd0;
        end else begin
            sym_cnt_nxt_s = sym_cnt_r + 8'd1;
        end

        // Complete SIGNAL word as it would be after shifting in this bit
        sig_word_s    = {sig_sr_r, In_bit};
        sig_good_s    = (sig_word_s[SIG_RSVD] == 1'b0)
                     && even_parity_ok(sig_word_s[SIG_RATE_MSB:SIG_PARITY])
                     && (sig_word_s[SIG_TAIL_MSB:SIG_TAIL_LSB] == 6'd0)
                     && (sig_word_s[SIG_LEN_MSB:SIG_LEN_LSB] != 12'd0);

        scr_load_s    = consume_s && (state_r == ST_SERVICE)
                     && (bit_cnt_r < 15'(SEED_BITS));
        scr_adv_s     = consume_s
                     && (((state_r == ST_SERVICE) && (bit_cnt_r >= 15'(SEED_BITS)))
                         || (state_r == ST_PSDU) || (state_r == ST_TAIL));
        plain_bit_s   = In_bit ^ seq_bit_s;
    end

    // Next-state logic: the state only moves on consumed bits, or on Start
    always_comb begin
        state_nxt_s = state_r;
        if (Start) begin
            state_nxt_s = ST_HUNT;
        end else if (!In_valid) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_HUNT: begin
                    if (run_hit_s) begin
                        state_nxt_s = ST_SIGNAL;
                    end else begin
                        state_nxt_s = ST_HUNT;
                    end
                end
                ST_SIGNAL: begin
                    if (!sig_last_s) begin
                        state_nxt_s = ST_SIGNAL;
                    end else if (sig_good_s) begin
                        state_nxt_s = ST_SERVICE;
                    end else begin
                        state_nxt_s = ST_HUNT;
                    end
                end
                ST_SERVICE: begin
                    if (svc_last_s) begin
                        state_nxt_s = ST_PSDU;
                    end else begin
                        state_nxt_s = ST_SERVICE;
                    end
                end
                ST_PSDU: begin
                    if (psdu_end_s) begin
                        state_nxt_s = ST_TAIL;
                    end else begin
                        state_nxt_s = ST_PSDU;
                    end
                end
                ST_TAIL: begin
                    // Skip PAD entirely when the tail already ends on a symbol boundary
                    if (!tail_last_s) begin
                        state_nxt_s = ST_TAIL;
                    end else if (sym_wrap_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_PAD;
                    end
                end
                ST_PAD: begin
                    if (sym_wrap_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_PAD;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: counters, SIGNAL capture, byte assembly, registered outputs and pulses
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            run_cnt_r    <= 7'd0;
            bit_cnt_r    <= 15'd0;
            sym_cnt_r    <= 8'd0;
            sig_sr_r     <= 23'd0;
            byte_sr_r    <= 7'd0;
            rate_r       <= 4'd0;
            length_r     <= 12'd0;
            signal_ok_r  <= 1'b0;
            signal_err_r <= 1'b0;
            data_valid_r <= 1'b0;
            data_bit_r   <= 1'b0;
            byte_valid_r <= 1'b0;
            data_byte_r  <= 8'd0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            // Pulses are single-cycle irrespective of In_valid
            signal_ok_r  <= 1'b0;
            signal_err_r <= 1'b0;
            data_valid_r <= 1'b0;
            byte_valid_r <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= (state_nxt_s != ST_IDLE);

            if (Start) begin
                // Abort: clear every counter; Rate/Length are kept
                run_cnt_r <= 7'd0;
                bit_cnt_r <= 15'd0;
                sym_cnt_r <= 8'd0;
                sig_sr_r  <= 23'd0;
                byte_sr_r <= 7'd0;
            end else if (In_valid) begin
                case (state_r)
                    ST_IDLE: begin
                        run_cnt_r <= 7'd0;
                    end
                    ST_HUNT: begin
                        bit_cnt_r <= 15'd0;
                        if (run_hit_s) begin
                            run_cnt_r <= 7'd0;
                        end else begin
                            run_cnt_r <= run_cnt_nxt_s;
                        end
                    end
                    ST_SIGNAL: begin
                        sig_sr_r <= sig_word_s[22:0];
                        if (sig_last_s) begin
                            bit_cnt_r <= 15'd0;
                            sym_cnt_r <= 8'd0;
                            run_cnt_r <= 7'd0;
                            if (sig_good_s) begin
                                rate_r      <= sig_word_s[SIG_RATE_MSB:SIG_RATE_LSB];
                                length_r    <= sig_word_s[SIG_LEN_MSB:SIG_LEN_LSB];
                                signal_ok_r <= 1'b1;
                            end else begin
                                signal_err_r <= 1'b1;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_inc_s;
                        end
                    end
                    ST_SERVICE: begin
                        sym_cnt_r <= sym_cnt_nxt_s;
                        if (svc_last_s) begin
                            bit_cnt_r <= 15'd0;
                        end else begin
                            bit_cnt_r <= bit_cnt_inc_s;
                        end
                    end
                    ST_PSDU: begin
                        sym_cnt_r    <= sym_cnt_nxt_s;
                        data_valid_r <= 1'b1;
                        data_bit_r   <= plain_bit_s;
                        // Bytes fill from bit 0 upward: new bits enter at the top
                        byte_sr_r    <= {plain_bit_s, byte_sr_r[6:1]};
                        if (bit_cnt_r[2:0] == 3'd7) begin
                            byte_valid_r <= 1'b1;
                            data_byte_r  <= {plain_bit_s, byte_sr_r};
                        end
                        if (psdu_end_s) begin
                            bit_cnt_r <= 15'd0;
                        end else begin
                            bit_cnt_r <= bit_cnt_inc_s;
                        end
                    end
                    ST_TAIL: begin
                        sym_cnt_r <= sym_cnt_nxt_s;
                        if (tail_last_s) begin
                            bit_cnt_r    <= 15'd0;
                            frame_done_r <= sym_wrap_s;
                        end else begin
                            bit_cnt_r <= bit_cnt_inc_s;
                        end
                    end
                    ST_PAD: begin
                        sym_cnt_r    <= sym_cnt_nxt_s;
                        frame_done_r <= sym_wrap_s;
                    end
                    default: begin
                        run_cnt_r <= 7'd0;
                    end
                endcase
            end
        end
    end

    assign Rate       = rate_r;
    assign Length     = length_r;
    assign Signal_ok  = signal_ok_r;
    assign Signal_err = signal_err_r;
    assign Data_valid = data_valid_r;
    assign Data_bit   = data_bit_r;
    assign Byte_valid = byte_valid_r;
    assign Data_byte  = data_byte_r;
    assign Frame_done = frame_done_r;
    assign Busy       = busy_r;

endmodule

// File: tb/tb_rx_deframer.sv
// ----------------------------------------------------------------------------
// tb_rx_deframer
// Directed frame sequence with randomized payload, lengths and input gaps.
// Frames are built from the framing rules:
//   - preamble and SIGNAL word
//   - SERVICE, payload, tail and pad bits
//   - DATA bits scrambled with the recurrence x[n] = x[n-7] ^ x[n-4]
// The decoded bytes, bits and status are compared with the original payload.
// ----------------------------------------------------------------------------
module tb_rx_deframer;

    localparam int N_DBPS = 24;
    localparam int PRE    = 96;
    localparam int TAILB  = 6;

    logic        Clock    = 1'b0;
    logic        Reset    = 1'b1;
    logic        Start    = 1'b0;
    logic        In_valid = 1'b0;
    logic        In_bit   = 1'b0;
    logic [3:0]  Rate;
    logic [11:0] Length;
    logic        Signal_ok;
    logic        Signal_err;
    logic        Data_valid;
    logic        Data_bit;
    logic        Byte_valid;
    logic [7:0]  Data_byte;
    logic        Frame_done;
    logic        Busy;

    int checks = 0;
    int errors = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int done_cnt = 0;

    logic [7:0]  got_bytes[$];
    logic        got_bits[$];
    logic [7:0]  payload[32];
    logic [3:0]  exp_rate = 4'd0;
    logic [11:0] exp_len  = 12'd0;

    rx_deframer dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .In_valid   (In_valid),
        .In_bit     (In_bit),
        .Rate       (Rate),
        .Length     (Length),
        .Signal_ok  (Signal_ok),
        .Signal_err (Signal_err),
        .Data_valid (Data_valid),
        .Data_bit   (Data_bit),
        .Byte_valid (Byte_valid),
        .Data_byte  (Data_byte),
        .Frame_done (Frame_done),
        .Busy       (Busy)
    );

    always #5 Clock = ~Clock;

    // Output monitor, sampled away from the active edge
    always @(negedge Clock) begin
        if (Byte_valid) got_bytes.push_back(Data_byte);
        if (Data_valid) got_bits.push_back(Data_bit);
        if (Signal_ok)  ok_cnt++;
        if (Signal_err) err_cnt++;
        if (Frame_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One consumed bit, preceded by a random number of idle cycles with junk data
    task automatic drive_bit(input logic b, input int gap_pct);
        while (int'($urandom_range(0, 99)) < gap_pct) begin
            In_valid = 1'b0;
            In_bit   = 1'($urandom);
            @(posedge Clock); #1;
        end
        In_valid = 1'b1;
        In_bit   = b;
        @(posedge Clock); #1;
        In_valid = 1'b0;
    endtask

    // bad_kind: 0 none, 1 parity flipped, 2 reserved set, 3 nonzero tail
    function automatic logic [23:0] make_sig(input logic [3:0] rate, input logic [11:0] len,
                                             input int bad_kind);
        logic [23:0] s;
        s[23:20] = rate;
        s[19]    = (bad_kind == 2);
        s[18:7]  = len;
        s[6]     = ^s[23:7];
        if (bad_kind == 1) s[6] = ~s[6];
        s[5:0]   = (bad_kind == 3) ? 6'b000100 : 6'b000000;
        return s;
    endfunction

    task automatic send_frame(input logic [3:0] rate, input logic [11:0] len, input int bad_kind,
                              input bit do_start, input int slip, input int gap,
                              input int cut_byte, input int cut_kind);
        logic [23:0] sig;
        logic        data[$];
        logic        hist[$];
        logic        seed[7];
        logic        expect_ok;
        logic        xn;
        int          n_pre_pad;
        int          pad;
        int          done0;
        int          ok0;
        int          err0;

        seed      = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        sig       = make_sig(rate, len, bad_kind);
        expect_ok = (bad_kind == 0) && (len != 12'd0);

        // DATA plaintext: SERVICE zeros, payload LSB first, tail, pad to N_DBPS
        for (int i = 0; i < 16; i++) data.push_back(1'b0);
        for (int i = 0; i < int'(len); i++)
            for (int b = 0; b < 8; b++) data.push_back(payload[i][b]);
        for (int i = 0; i < TAILB; i++) data.push_back(1'b0);
        n_pre_pad = data.size();
        pad = (N_DBPS - (n_pre_pad % N_DBPS)) % N_DBPS;
        for (int i = 0; i < pad; i++) data.push_back(1'b0);
        for (int i = 0; i < 7; i++) hist.push_back(seed[i]);
        for (int n = 0; n < data.size(); n++) begin
            xn = hist[hist.size() - 7] ^ hist[hist.size() - 4];
            hist.push_back(xn);
            data[n] = data[n] ^ xn;
        end

        ok0 = ok_cnt; err0 = err_cnt; done0 = done_cnt;
        got_bytes.delete();
        got_bits.delete();

        if (do_start) begin
            Start = 1'b1;
            @(posedge Clock); #1;
            Start = 1'b0;
            check("busy_after_start", 32'(Busy), 32'd1);
        end
        for (int i = 0; i < slip; i++) drive_bit(i % 2 == 0, gap);
        // One wrong bit breaks the run (expected is 1 after an even count)
        if (slip > 0) drive_bit(slip % 2 != 0, gap);
        for (int i = 0; i < PRE; i++) drive_bit(i % 2 == 0, gap);
        for (int i = 23; i >= 0; i--) drive_bit(sig[i], gap);

        check("signal_ok_pulse", 32'(Signal_ok), 32'(expect_ok));
        check("signal_err_pulse", 32'(Signal_err), 32'(!expect_ok));
        if (expect_ok) begin
            exp_rate = rate;
            exp_len  = len;
        end
        check("rate", 32'(Rate), 32'(exp_rate));
        check("length", 32'(Length), 32'(exp_len));
        if (!expect_ok) begin
            @(posedge Clock); #1;
            check("signal_err_one_cycle", 32'(Signal_err), 32'd0);
            check("busy_after_reject", 32'(Busy), 32'd1);
            return;
        end

        for (int i = 0; i < data.size(); i++) begin
            if (cut_byte >= 0 && i == 16 + 8 * cut_byte + 3) begin
                if (cut_kind == 0) begin
                    Start = 1'b1;
                    @(posedge Clock); #1;
                    Start = 1'b0;
                    check("busy_after_abort", 32'(Busy), 32'd1);
                    repeat (40) @(posedge Clock);
                    #1;
                    check("no_done_after_abort", 32'(done_cnt - done0), 32'd0);
                    check("bytes_before_abort", 32'(got_bytes.size()), 32'(cut_byte));
                    check("rate_kept_on_abort", 32'(Rate), 32'(exp_rate));
                end else begin
                    #2 Reset = 1'b0;
                    #1;
                    check("rst_rate", 32'(Rate), 32'd0);
                    check("rst_length", 32'(Length), 32'd0);
                    check("rst_busy", 32'(Busy), 32'd0);
                    check("rst_pulses", 32'({Signal_ok, Signal_err, Byte_valid, Frame_done}), 32'd0);
                    check("rst_data", 32'({Data_valid, Data_bit, Data_byte}), 32'd0);
                    repeat (2) @(posedge Clock);
                    #1 Reset = 1'b1;
                    exp_rate = 4'd0;
                    exp_len  = 12'd0;
                end
                return;
            end
            drive_bit(data[i], gap);
            if (i == data.size() - 2) begin
                check("no_early_done", 32'(Frame_done), 32'd0);
                check("busy_before_end", 32'(Busy), 32'd1);
            end
        end
        check("frame_done", 32'(Frame_done), 32'd1);
        check("busy_after_done", 32'(Busy), 32'd0);
        @(posedge Clock); #1;
        check("frame_done_one_cycle", 32'(Frame_done), 32'd0);
        @(negedge Clock);
        check("done_count", 32'(done_cnt - done0), 32'd1);
        check("ok_count", 32'(ok_cnt - ok0), 32'd1);
        check("err_count", 32'(err_cnt - err0), 32'd0);
        check("byte_count", 32'(got_bytes.size()), 32'(len));
        check("bit_count", 32'(got_bits.size()), 32'(8 * int'(len)));
        for (int i = 0; i < got_bytes.size() && i < int'(len); i++)
            check("psdu_byte", 32'(got_bytes[i]), 32'(payload[i]));
        for (int k = 0; k < got_bits.size() && k < 8 * int'(len); k++)
            check("psdu_bit", 32'(got_bits[k]), 32'(payload[k / 8][k % 8]));
    endtask

    initial begin
        logic [23:0] sw;
        int          ok_before;

        for (int i = 0; i < 32; i++) payload[i] = 8'($urandom);

        // Reset state
        #2 Reset = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check("reset_rate", 32'(Rate), 32'd0);
        check("reset_length", 32'(Length), 32'd0);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_pulses", 32'({Signal_ok, Signal_err, Byte_valid, Frame_done}), 32'd0);
        check("reset_data", 32'({Data_valid, Data_bit, Data_byte}), 32'd0);
        Reset = 1'b1;
        @(posedge Clock); #1;

        // Bad SIGNAL (parity flipped), then a good frame picked up from HUNT
        send_frame(4'hD, 12'h010, 1, 1'b1, 0, 0, -1, 0);
        send_frame(4'hD, 12'h010, 0, 1'b0, 0, 0, -1, 0);
        // Other rejection rules: reserved bit, nonzero tail, zero length
        send_frame(4'hB, 12'h005, 2, 1'b1, 0, 0, -1, 0);
        send_frame(4'h3, 12'h007, 3, 1'b0, 0, 0, -1, 0);
        send_frame(4'h9, 12'h000, 0, 1'b0, 0, 0, -1, 0);
        send_frame(4'h5, 12'h003, 0, 1'b0, 0, 0, -1, 0);

        // Nominal, preamble slip, input gaps
        send_frame(4'hD, 12'h010, 0, 1'b1, 0, 0, -1, 0);
        send_frame(4'hD, 12'h010, 0, 1'b1, 50, 0, -1, 0);
        send_frame(4'hD, 12'h010, 0, 1'b1, 0, 50, -1, 0);

        // Random rates and lengths with light gaps
        for (int k = 0; k < 3; k++)
            send_frame(4'($urandom_range(0, 15)), 12'($urandom_range(1, 32)), 0, 1'b1, 0, 20, -1, 0);

        // Abort mid-PSDU, then the next frame from HUNT
        send_frame(4'hD, 12'h010, 0, 1'b1, 0, 0, 5, 0);
        send_frame(4'h7, 12'h009, 0, 1'b0, 0, 0, -1, 0);

        // Asynchronous reset mid-frame
        send_frame(4'hA, 12'h008, 0, 1'b1, 0, 0, 3, 1);

        // In IDLE without Start, a full preamble and SIGNAL must be ignored
        ok_before = ok_cnt;
        sw = make_sig(4'hD, 12'h010, 0);
        for (int i = 0; i < PRE; i++) drive_bit(i % 2 == 0, 0);
        for (int i = 23; i >= 0; i--) drive_bit(sw[i], 0);
        @(negedge Clock);
        check("idle_ignores_input", 32'(ok_cnt - ok_before), 32'd0);
        check("idle_busy", 32'(Busy), 32'd0);

        // Recovery after reset
        send_frame(4'hD, 12'h010, 0, 1'b1, 0, 0, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_deframer.md
# rx_deframer

Receive-side counterpart of the 802.11 transmitter. It consumes the serial bitstream after the receive front end, which supplies the raw preamble bits followed by de-interleaved, Viterbi-decoded SIGNAL/DATA bits. It locks onto the preamble, parses and checks the 24-bit SIGNAL field, descrambles the DATA field, and delivers PSDU bits and bytes with frame status to the MAC-side consumer.

## Interface
- `N_DBPS`, default 24: data bits per OFDM symbol; DATA field is padded to a multiple of this.
- `PREAMBLE_BITS`, default 96: consecutive alternating bits required for lock.
- `TAIL_BITS`, default 6: DATA tail bits discarded after the PSDU.
- `Clock` in, 1: single clock; all state changes on the rising edge.
- `Reset` in, 1: asynchronous, active-low.
- `Start` in, 1: arm/re-arm. Aborts any frame in progress and enters HUNT.
- `In_valid` in, 1: `In_bit` is valid this cycle. Gaps are allowed at any time.
- `In_bit` in, 1: next received bit.
- `Rate` out, 4: RATE from the last accepted SIGNAL, first received bit in bit 3.
- `Length` out, 12: LENGTH in bytes from the last accepted SIGNAL, first received bit in bit 11.
- `Signal_ok` out, 1: one-cycle pulse when SIGNAL is accepted.
- `Signal_err` out, 1: one-cycle pulse when SIGNAL is rejected.
- `Data_valid` out, 1: `Data_bit` is a descrambled PSDU bit.
- `Data_bit` out, 1: descrambled PSDU bit.
- `Byte_valid` out, 1: `Data_byte` is complete.
- `Data_byte` out, 8: assembled PSDU byte, first bit received in bit 0.
- `Frame_done` out, 1: one-cycle pulse after the last pad bit is consumed.
- `Busy` out, 1: high in every state except IDLE.

## Operation
- States: IDLE, HUNT, SIGNAL, SERVICE, PSDU, TAIL, PAD.
- Bits are consumed only on cycles with `In_valid=1`. Counters and state hold otherwise.
- **IDLE**: entered at reset and after `Frame_done`. `Start` moves to HUNT.
- **HUNT**: the expected bit alternates starting from 1 (0xAA, MSB first).
  - On a match, the run counter increments.
  - On a mismatch, the run counter restarts: it becomes 1 if the bit is 1, otherwise 0.
  - When the counter reaches `PREAMBLE_BITS`, move to SIGNAL.
  - Extra alternating bits are not tolerated. The first SIGNAL bit is taken immediately after the 96th preamble bit.
- **SIGNAL**: shifts in 24 bits in this order: RATE[3:0] MSB first, reserved, LENGTH[11:0] MSB first, parity, tail[5:0].
  - Accept only if all hold: reserved=0, XOR of the first 18 bits =0 (even parity), tail=000000, LENGTH≠0.
  - Accept: latch `Rate` and `Length`, pulse `Signal_ok`, move to SERVICE.
  - Reject: pulse `Signal_err`, keep `Rate`/`Length` unchanged, return to HUNT.
- **SERVICE**: 16 bits.
  - The first 7 received bits are loaded directly into the 7-bit descrambler state (seed recovery, since the plaintext is zero).
  - The remaining 9 bits are descrambled and discarded.
- **PSDU**: 8×`Length` bits.
  - Each bit is XORed with descrambler output (x^7+x^4+1) and emitted on `Data_bit`/`Data_valid`.
  - Bytes are assembled LSB first.
- **TAIL**: `TAIL_BITS` bits, consumed and discarded. The descrambler still advances.
- **PAD**: consume bits until the count of DATA bits (SERVICE+PSDU+TAIL+PAD) is a multiple of `N_DBPS`, then pulse `Frame_done` and go to IDLE.
  - If the count is already a multiple on entry, zero pad bits are consumed and `Frame_done` pulses on the cycle after the last tail bit.
- The symbol counter wraps mod `N_DBPS` and is cleared on SERVICE entry.
- `Start` during a frame: abort, clear all counters, enter HUNT. No `Frame_done` pulse; `Rate`/`Length` are retained.
- `Start` and a same-cycle `In_valid`: `Start` wins and the bit is dropped.

## Timing
- Reset values: all pulses, `Data_bit`, `Data_byte`, `Rate`, `Length` and `Busy` are 0; state is IDLE.
- `Data_valid`/`Data_bit` are registered: asserted the cycle after the PSDU bit is sampled.
- `Byte_valid` is asserted in the same cycle as `Data_valid` for the 8th bit of the byte.
- `Signal_ok`/`Signal_err` fire the cycle after the 24th SIGNAL bit.
- `Frame_done` fires the cycle after the final DATA bit.
- Pulses last exactly one cycle regardless of `In_valid`.
- Widths:
  - PSDU bit counter: 15 bits (max 4095×8).
  - Preamble counter: 7 bits.
  - Symbol counter: 8 bits.

## Structure
- The shared `phy_pkg` holds:
  - state encodings;
  - `N_DBPS`, `PREAMBLE_BITS`, `TAIL_BITS` and the SIGNAL field offsets;
  - the scrambler polynomial taps, which are also used by the transmitter's scrambler.
- One sub-module, `descrambler`: 7-bit LFSR with `Load`, `Seed_in` and `Advance`, and output `Seq_bit`. This block owns the FSM, counters and byte assembly.

## Test plan
- **Nominal frame.** Stimulus: `Start`, then 96 preamble bits, then SIGNAL RATE=1101, LENGTH=0x010, parity=0, then 16 bytes scrambled with seed 1011101. Required: `Signal_ok`; `Rate`=0xD, `Length`=0x010; 16 `Byte_valid` with the original bytes; 18 pad bits consumed (150→168); `Frame_done`; `Busy`=0.
- **Bad SIGNAL.** Stimulus: same frame with the parity bit flipped. Required: `Signal_err` one cycle after bit 24; FSM back in HUNT; `Rate`/`Length` still 0. Then a valid frame still decodes.
- **Preamble slip.** Stimulus: 50 alternating bits, one error, then 96 good bits. Required: lock only after the final 96 bits; the SIGNAL is parsed correctly.
- **Input gaps.** Stimulus: `In_valid` randomly low 50% of the time through the nominal frame. Required: identical bytes and status to the nominal frame.
- **Abort.** Stimulus: `Start` asserted mid-PSDU (byte 5). Required: no `Frame_done`; the next full frame decodes correctly.
- **Reset.** Stimulus: `Reset` low mid-frame. Required: all outputs 0 immediately (asynchronously), state IDLE.
